spook_bdo_formatter: RTL and testbench
======================================

# spook_bdo_formatter

Output formatter directly downstream of the Spook cipher core. It consumes the core's `bdo` word stream and its `msg_auth` result, and buffers one rate block of up to 256 bits. For each block it emits a segment header word, then the data words, then a final status word on the output data bus of the post-processing interface.

## Interface
Parameters:
- `BUF_WORDS`, default 8: block buffer depth in 32-bit words (Spook rate, 256 bits).

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `bdo`  in  32  data word from the cipher core, big-endian byte order.
- `bdo_valid`  in  1  `bdo` word valid.
- `bdo_ready`  out  1  formatter accepts a `bdo` word.
- `bdo_size`  in  4  valid bytes in the current word, 1..4.
- `end_of_block`  in  1  current word closes the block.
- `bdo_last`  in  1  current block is the last one of its segment type; sampled with `end_of_block`.
- `bdo_tag`  in  1  current word belongs to the tag; sampled on the first word of the block.
- `decrypt`  in  1  operation mode; sampled on the first word of the block.
- `msg_auth`  in  1  tag comparison result: 1 = pass.
- `msg_auth_valid`  in  1  `msg_auth` valid.
- `msg_auth_ready`  out  1  formatter accepts `msg_auth`.
- `do_data`  out  32  output word.
- `do_valid`  out  1  `do_data` valid.
- `do_ready`  in  1  downstream accepts `do_data`.
- `do_last`  out  1  current `do_data` word is the final word of the operation (the status word).

## Operation
- The FSM has five states: FILL, HDR, DATA, WAIT_AUTH, STATUS. The state after reset is FILL.
- **FILL**
  - `bdo_ready = (wcnt < BUF_WORDS)`.
  - On each `bdo_valid & bdo_ready`, the word is written to `buf[wcnt]`, `wcnt` is incremented, and `bcnt += bdo_size`.
  - Bytes beyond `bdo_size` are zeroed on write. Byte 0 is `[31:24]`.
  - On the first word of a block, `type_r` is latched: 1000 if `bdo_tag`, else 0100 if `decrypt` (plaintext), else 0101 (ciphertext).
  - An accepted word with `end_of_block` set, or the accept that makes `wcnt == BUF_WORDS`, moves the FSM to HDR. `last_r` is latched as `bdo_last & end_of_block`. A full buffer without `end_of_block` gives `last_r = 0`.
  - Idle with `decrypt_r = 1` and `msg_auth_valid`: go to WAIT_AUTH handling. `msg_auth_ready` is high in FILL only when `wcnt == 0` and the previous segment was a last plaintext block.
- **HDR**
  - Drives the header word:
    - `[31:28]` = `type_r`
    - `[27]` = 0
    - `[26]` = 0
    - `[25]` = `last_r`
    - `[24]` = `last_r`
    - `[23:16]` = 0
    - `[15:0]` = `bcnt` (zero-extended)
  - `do_valid` = 1. On `do_ready`, go to DATA with `rcnt = 0`.
- **DATA**
  - `do_data = buf[rcnt]`, `do_valid` = 1.
  - On `do_ready`, `rcnt++`. When `rcnt == wcnt-1` is accepted, clear `wcnt`, `bcnt` and `rcnt`. The next state is then:
    - STATUS with status 1110, if the block was a last tag block (encrypt done);
    - WAIT_AUTH, if it was a last plaintext block;
    - FILL otherwise.
- **WAIT_AUTH**
  - `msg_auth_ready` = 1.
  - On `msg_auth_valid`, latch the status as 1110 if `msg_auth`, else 1111, and go to STATUS.
- **STATUS**
  - `do_data = {status, 28'h0}`, `do_valid` = 1, `do_last` = 1.
  - On `do_ready`, return to FILL.
- Empty segments (no `bdo` words) produce no header.

## Timing
- Reset values: `bdo_ready`, `msg_auth_ready`, `do_valid` and `do_last` are 0, and `do_data` is 32'h0, while `rst` = 0. `wcnt`, `bcnt`, `rcnt` and all latches clear, and the state is FILL.
- `bdo_ready` is 1 in the first cycle after reset deassertion.
- Reset asserted mid-operation discards buffered data immediately. No partial segment is emitted afterwards.
- All outputs are decoded combinationally from registered state. No output depends combinationally on `do_ready` or `bdo_valid`.
- Latency: the header is valid the cycle after the closing `bdo` word is accepted. With `do_ready` held high, data words follow at one per cycle.
- `bdo_ready` is 0 in HDR, DATA, WAIT_AUTH and STATUS, so there is no overlap between fill and drain.
- `do_data` and `do_valid` are held stable while `do_valid & !do_ready`.
- `msg_auth_valid` outside WAIT_AUTH is ignored and not latched.
- `bcnt` is 6 bits (maximum 32 for `BUF_WORDS` = 8). `bdo_size` = 0 is illegal; behaviour is undefined.

## Test plan
- **Encrypt, 5-byte message.**
  - Stimulus: two `bdo` words, sizes 4 and 1, the second with `end_of_block` and `bdo_last`, `decrypt` = 0. Then 4 tag words with `bdo_tag`, the last with `end_of_block` and `bdo_last`.
  - Response:
    - `do_data` sequence: 53000005, word0, `{b4,24'h0}`, then 83000010 and the 4 tag words;
    - then E0000000 with `do_last` = 1.
- **Decrypt, 8-byte message, authentication fail.**
  - Stimulus: two full words with `bdo_last`, then `msg_auth_valid` = 1 with `msg_auth` = 0.
  - Response: 43000008, two words, then F0000000 with `do_last`.
  - `msg_auth_ready` is high only after the second data word is accepted.
- **Full buffer, 40-byte message.**
  - Stimulus: 10 full words, `end_of_block` on word 10 only.
  - Response:
    - first segment header 50000020 after 8 words, with `bdo_ready` = 0 while draining;
    - second segment header 53000008.
- **Backpressure.**
  - Stimulus: `do_ready` toggles 1,0,0,1 during DATA.
  - Response: `do_data` is unchanged across stalled cycles, and no word is duplicated or lost.
- **Reset mid-drain.**
  - Stimulus: `rst` = 0 during DATA word 1 of 3.
  - Response: all outputs are 0 in the same cycle. After release, `bdo_ready` = 1, and a fresh 4-byte block yields header 53000004.
- **Stray authentication.**
  - Stimulus: `msg_auth_valid` pulsed during FILL in encrypt mode.
  - Response: no status word is emitted.

Source files
------------

// File: rtl/spook_bdo_formatter.sv
// Spook output formatter: buffers one rate block of bdo words, then emits a
// segment header, the buffered data words and, at the end of an operation, a status word.
module spook_bdo_formatter #(
  parameter int unsigned BUF_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bdo,
  input  logic        bdo_valid,
  output logic        bdo_ready,
  input  logic [3:0]  bdo_size,
  input  logic        end_of_block,
  input  logic        bdo_last,
  input  logic        bdo_tag,
  input  logic        decrypt,
  input  logic        msg_auth,
  input  logic        msg_auth_valid,
  output logic        msg_auth_ready,
  output logic [31:0] do_data,
  output logic        do_valid,
  input  logic        do_ready,
  output logic        do_last
);

  localparam int unsigned WCNT_W = $clog2(BUF_WORDS + 1);
  localparam int unsigned IDX_W  = (BUF_WORDS > 1) ? $clog2(BUF_WORDS) : 1;
  localparam int unsigned BCNT_W = $clog2(4 * BUF_WORDS + 1);

  localparam logic [3:0] TYPE_TAG = 4'b1000;
  localparam logic [3:0] TYPE_PT  = 4'b0100;
  localparam logic [3:0] TYPE_CT  = 4'b0101;
  localparam logic [3:0] ST_PASS  = 4'b1110;
  localparam logic [3:0] ST_FAIL  = 4'b1111;

  typedef enum logic [2:0] {
    S_FILL,
    S_HDR,
    S_DATA,
    S_WAIT_AUTH,
    S_STATUS
  } state_e;

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [WCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [3:0]          type_q, type_d;
  logic [3:0]          status_q, status_d;
  logic                last_q, last_d;
  logic                decrypt_q, decrypt_d;
  logic                pend_q, pend_d;
  logic [31:0]         blk_q [BUF_WORDS];
  logic [31:0]         blk_d [BUF_WORDS];
  logic [31:0]         wmask;
  logic                fill_acc;

  // Keep only the valid leading bytes; byte 0 sits in [31:24].
  always_comb begin
    wmask = 32'hFFFF_FFFF;
    case (bdo_size)
      4'd1:    wmask = 32'hFF00_0000;
      4'd2:    wmask = 32'hFFFF_0000;
      4'd3:    wmask = 32'hFFFF_FF00;
      default: wmask = 32'hFFFF_FFFF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    rcnt_d    = rcnt_q;
    bcnt_d    = bcnt_q;
    type_d    = type_q;
    status_d  = status_q;
    last_d    = last_q;
    decrypt_d = decrypt_q;
    pend_d    = pend_q;
    blk_d     = blk_q;
    fill_acc  = 1'b0;

    bdo_ready      = 1'b0;
    msg_auth_ready = 1'b0;
    do_valid       = 1'b0;
    do_last        = 1'b0;
    do_data        = '0;

    case (state_q)
      S_FILL: begin
        // Gated by rst so nothing is advertised while reset is held.
        bdo_ready      = rst && (wcnt_q < WCNT_W'(BUF_WORDS));
        msg_auth_ready = rst && (wcnt_q == '0) && pend_q && decrypt_q;
        fill_acc       = bdo_valid && bdo_ready;
        if (fill_acc) begin
          blk_d[wcnt_q[IDX_W-1:0]] = bdo & wmask;
          wcnt_d = wcnt_q + WCNT_W'(1);
          bcnt_d = bcnt_q + BCNT_W'(bdo_size);
          if (wcnt_q == '0) begin
            type_d    = bdo_tag ? TYPE_TAG : (decrypt ? TYPE_PT : TYPE_CT);
            decrypt_d = decrypt;
          end
          if (end_of_block || (wcnt_d == WCNT_W'(BUF_WORDS))) begin
            last_d  = bdo_last && end_of_block;
            state_d = S_HDR;
          end
        end else if (msg_auth_ready && msg_auth_valid) begin
          status_d = msg_auth ? ST_PASS : ST_FAIL;
          pend_d   = 1'b0;
          state_d  = S_STATUS;
        end
      end

      S_HDR: begin
        do_valid = 1'b1;
        do_data  = {type_q, 2'b00, last_q, last_q, 8'h00, 16'(bcnt_q)};
        if (do_ready) begin
          rcnt_d  = '0;
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        do_valid = 1'b1;
        do_data  = blk_q[rcnt_q[IDX_W-1:0]];
        if (do_ready) begin
          if (rcnt_q == (wcnt_q - WCNT_W'(1))) begin
            wcnt_d = '0;
            bcnt_d = '0;
            rcnt_d = '0;
            if (last_q && (type_q == TYPE_TAG)) begin
              status_d = ST_PASS;
              state_d  = S_STATUS;
            end else if (last_q && (type_q == TYPE_PT)) begin
              pend_d  = 1'b1;
              state_d = S_WAIT_AUTH;
            end else begin
              state_d = S_FILL;
            end
          end else begin
            rcnt_d = rcnt_q + WCNT_W'(1);
          end
        end
      end

      S_WAIT_AUTH: begin
        msg_auth_ready = 1'b1;
        if (msg_auth_valid) begin
          status_d = msg_auth ? ST_PASS : ST_FAIL;
          pend_d   = 1'b0;
          state_d  = S_STATUS;
        end
      end

      S_STATUS: begin
        do_valid = 1'b1;
        do_last  = 1'b1;
        do_data  = {status_q, 28'h0};
        if (do_ready) state_d = S_FILL;
      end

      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FILL;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      bcnt_q    <= '0;
      type_q    <= '0;
      status_q  <= '0;
      last_q    <= 1'b0;
      decrypt_q <= 1'b0;
      pend_q    <= 1'b0;
      blk_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      rcnt_q    <= rcnt_d;
      bcnt_q    <= bcnt_d;
      type_q    <= type_d;
      status_q  <= status_d;
      last_q    <= last_d;
      decrypt_q <= decrypt_d;
      pend_q    <= pend_d;
      blk_q     <= blk_d;
    end
  end

endmodule

// File: tb/tb_spook_bdo_formatter.sv
// Cycle-accurate vector bench for spook_bdo_formatter: each record gives the inputs
// driven in a cycle and the outputs expected in that same cycle.
module tb_spook_bdo_formatter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bdo;
  logic        bdo_valid;
  logic        bdo_ready;
  logic [3:0]  bdo_size;
  logic        end_of_block;
  logic        bdo_last;
  logic        bdo_tag;
  logic        decrypt;
  logic        msg_auth;
  logic        msg_auth_valid;
  logic        msg_auth_ready;
  logic [31:0] do_data;
  logic        do_valid;
  logic        do_ready;
  logic        do_last;

  int n_chk  = 0;
  int n_fail = 0;
  int vidx   = 0;

  always #5 clk = ~clk;

  spook_bdo_formatter #(.BUF_WORDS(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .bdo            (bdo),
    .bdo_valid      (bdo_valid),
    .bdo_ready      (bdo_ready),
    .bdo_size       (bdo_size),
    .end_of_block   (end_of_block),
    .bdo_last       (bdo_last),
    .bdo_tag        (bdo_tag),
    .decrypt        (decrypt),
    .msg_auth       (msg_auth),
    .msg_auth_valid (msg_auth_valid),
    .msg_auth_ready (msg_auth_ready),
    .do_data        (do_data),
    .do_valid       (do_valid),
    .do_ready       (do_ready),
    .do_last        (do_last)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic [3:0]  sz;
    logic        eob;
    logic        lst;
    logic        tag;
    logic        dec;
    logic        rdy;
    logic        mav;
    logic        ma;
    logic        ebr;
    logic        edv;
    logic [31:0] edd;
    logic        edl;
    logic        emr;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic [3:0] sz,
                     input logic eob, input logic lst, input logic tag, input logic dec,
                     input logic rdy, input logic mav, input logic ma,
                     input logic ebr, input logic edv, input logic [31:0] edd,
                     input logic edl, input logic emr);
    vec_t r;
    r.v = v; r.d = d; r.sz = sz; r.eob = eob; r.lst = lst; r.tag = tag; r.dec = dec;
    r.rdy = rdy; r.mav = mav; r.ma = ma;
    r.ebr = ebr; r.edv = edv; r.edd = edd; r.edl = edl; r.emr = emr;
    vq.push_back(r);
  endtask

  // FILL cycle presenting a bdo word.
  task automatic wr(input logic [31:0] d, input logic [3:0] sz, input logic eob,
                    input logic lst, input logic tag, input logic dec);
    add(1'b1, d, sz, eob, lst, tag, dec, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // FILL cycle with no bdo word, optionally pulsing msg_auth_valid.
  task automatic idle(input logic mav, input logic ma);
    add(1'b0, 32'h0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mav, ma, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Output cycle; a junk closing bdo word is offered and must be refused.
  task automatic drain(input logic [31:0] edd, input logic rdy, input logic edl);
    add(1'b1, 32'hDEADBEEF, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, rdy, 1'b0, 1'b0,
        1'b0, 1'b1, edd, edl, 1'b0);
  endtask

  task automatic wauth(input logic mav, input logic ma);
    add(1'b0, 32'h0, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mav, ma, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.bdo_ready", vidx), 32'(bdo_ready), 32'(vq[i].ebr));
      chk($sformatf("v%0d.do_valid", vidx), 32'(do_valid), 32'(vq[i].edv));
      chk($sformatf("v%0d.do_last", vidx), 32'(do_last), 32'(vq[i].edl));
      chk($sformatf("v%0d.msg_auth_ready", vidx), 32'(msg_auth_ready), 32'(vq[i].emr));
      if (vq[i].edv) chk($sformatf("v%0d.do_data", vidx), do_data, vq[i].edd);
      bdo_valid      = vq[i].v;
      bdo            = vq[i].d;
      bdo_size       = vq[i].sz;
      end_of_block   = vq[i].eob;
      bdo_last       = vq[i].lst;
      bdo_tag        = vq[i].tag;
      decrypt        = vq[i].dec;
      do_ready       = vq[i].rdy;
      msg_auth_valid = vq[i].mav;
      msg_auth       = vq[i].ma;
      vidx++;
    end
    vq.delete();
  endtask

  task automatic clear_inputs();
    bdo_valid = 1'b0; bdo = '0; bdo_size = 4'd4; end_of_block = 1'b0; bdo_last = 1'b0;
    bdo_tag = 1'b0; decrypt = 1'b0; msg_auth = 1'b0; msg_auth_valid = 1'b0; do_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".bdo_ready"}, 32'(bdo_ready), 32'h0);
    chk({tag, ".msg_auth_ready"}, 32'(msg_auth_ready), 32'h0);
    chk({tag, ".do_valid"}, 32'(do_valid), 32'h0);
    chk({tag, ".do_last"}, 32'(do_last), 32'h0);
    chk({tag, ".do_data"}, do_data, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b1;
    #1;
    chk("post_reset.bdo_ready", 32'(bdo_ready), 32'h1);

    // Encrypt, 5-byte message, then 4-word tag
    wr(32'h11223344, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'hB4AABBCC, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(32'h53000005, 1'b1, 1'b0);
    drain(32'h11223344, 1'b1, 1'b0);
    drain(32'hB4000000, 1'b1, 1'b0);
    wr(32'hA0A1A2A3, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    wr(32'hA4A5A6A7, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    wr(32'hA8A9AAAB, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0);
    wr(32'hACADAEAF, 4'd4, 1'b1, 1'b1, 1'b1, 1'b0);
    drain(32'h83000010, 1'b1, 1'b0);
    drain(32'hA0A1A2A3, 1'b1, 1'b0);
    drain(32'hA4A5A6A7, 1'b1, 1'b0);
    drain(32'hA8A9AAAB, 1'b1, 1'b0);
    drain(32'hACADAEAF, 1'b1, 1'b0);
    drain(32'hE0000000, 1'b1, 1'b1);
    idle(1'b0, 1'b0);

    // Decrypt, 8-byte message, authentication fail, status stalled once
    wr(32'h01020304, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    wr(32'h05060708, 4'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    drain(32'h43000008, 1'b1, 1'b0);
    drain(32'h01020304, 1'b1, 1'b0);
    drain(32'h05060708, 1'b1, 1'b0);
    wauth(1'b0, 1'b0);
    wauth(1'b1, 1'b0);
    drain(32'hF0000000, 1'b0, 1'b1);
    drain(32'hF0000000, 1'b1, 1'b1);
    idle(1'b0, 1'b0);

    // Full buffer, 40-byte message
    for (int k = 0; k < 8; k++) wr(32'hA5000000 | 32'(k), 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    drain(32'h50000020, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) drain(32'hA5000000 | 32'(k), 1'b1, 1'b0);
    wr(32'hA5000008, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'hA5000009, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(32'h53000008, 1'b1, 1'b0);
    drain(32'hA5000008, 1'b1, 1'b0);
    drain(32'hA5000009, 1'b1, 1'b0);
    idle(1'b0, 1'b0);

    // Backpressure on header and data, non-last block with a 3-byte tail word
    wr(32'h10203040, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'h50607080, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'h778899AA, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    drain(32'h5000000B, 1'b0, 1'b0);
    drain(32'h5000000B, 1'b1, 1'b0);
    drain(32'h10203040, 1'b1, 1'b0);
    drain(32'h50607080, 1'b0, 1'b0);
    drain(32'h50607080, 1'b0, 1'b0);
    drain(32'h50607080, 1'b1, 1'b0);
    drain(32'h77889900, 1'b1, 1'b0);
    idle(1'b0, 1'b0);

    // Stray authentication in encrypt mode: nothing must come out
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // Fill a 3-word block and drain up to data word 1
    wr(32'h0BAD0001, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'h0BAD0002, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    wr(32'h0BAD0003, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(32'h5300000C, 1'b1, 1'b0);
    drain(32'h0BAD0001, 1'b1, 1'b0);
    run_vecs();

    // Reset mid-drain
    @(negedge clk);
    chk("mid_drain.do_data", do_data, 32'h0BAD0002);
    rst = 1'b0;
    clear_inputs();
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("release.bdo_ready", 32'(bdo_ready), 32'h1);
    chk("release.do_valid", 32'(do_valid), 32'h0);

    wr(32'hCAFEF00D, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    drain(32'h53000004, 1'b1, 1'b0);
    drain(32'hCAFEF00D, 1'b1, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    run_vecs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
